// File: rtl/bip_defs.sv
// bip_defs: shared opcode, accumulator-mux and state encodings for the BIP control unit
package bip_defs;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  typedef enum logic [4:0] {
    OP_HALT = 5'h00, OP_STO, OP_LD, OP_LDI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_BEQ, OP_BNE, OP_JMP
  } opcode_t;
  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
  } ctrl_t;
endpackage

// File: rtl/bip_opcode_decoder.sv
// bip_opcode_decoder: opcode to datapath control vector and instruction class flags
module bip_opcode_decoder
  import bip_defs::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  input  logic             acc_zero,
  output ctrl_t            ctrl,
  output logic             is_mem,
  output logic             is_branch,
  output logic             is_halt,
  output logic             is_illegal
);
  always_comb begin
    ctrl = '0;
    is_mem = 1'b0;
    is_branch = 1'b0;
    is_halt = 1'b0;
    is_illegal = 1'b0;
    case (opc)
      OP_HALT: is_halt = 1'b1;
      OP_STO: begin ctrl = {SELA_RAM, 5'b00001}; is_mem = 1'b1; end
      OP_LD: begin ctrl = {SELA_RAM, 5'b00110}; is_mem = 1'b1; end
      OP_LDI: ctrl = {SELA_IMM, 5'b10100};
      OP_ADD: begin ctrl = {SELA_ALU, 5'b01110}; is_mem = 1'b1; end
      OP_ADDI: ctrl = {SELA_ALU, 5'b11100};
      OP_SUB: begin ctrl = {SELA_ALU, 5'b00110}; is_mem = 1'b1; end
      OP_SUBI: ctrl = {SELA_ALU, 5'b10100};
      OP_BEQ: is_branch = acc_zero;
      OP_BNE: is_branch = !acc_zero;
      OP_JMP: is_branch = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/bip_control_fsm.sv
// bip_control_fsm: multi-cycle fetch/decode/execute sequencer for the BIP processor
module bip_control_fsm
  import bip_defs::*;
#(
  parameter int PC_W      = 11,
  parameter int OPERAND_W = 11,
  parameter int OPC_W     = 5,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OPC_W+OPERAND_W-1:0] instr,
  input  logic                   acc_zero,
  input  logic                   mem_ready,
  input  logic                   run,
  input  logic                   step,
  output logic [PC_W-1:0]        pc,
  output logic [OPERAND_W-1:0]   operand,
  output logic                   wr_acc,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   op,
  output logic                   wr_ram,
  output logic                   rd_ram,
  output logic                   halted,
  output logic                   illegal,
  output logic                   busy,
  output logic [CNT_W-1:0]       cycle_cnt
);
  state_t state, state_nx;
  logic [OPC_W+OPERAND_W-1:0] ir;
  ctrl_t ctrl;
  logic is_mem, is_branch, is_halt, is_illegal;
  logic in_exec, done, stop;
  bip_opcode_decoder #(.OPC_W(OPC_W)) u_dec (
    .opc       (ir[OPC_W+OPERAND_W-1 -: OPC_W]),
    .acc_zero  (acc_zero),
    .ctrl      (ctrl),
    .is_mem    (is_mem),
    .is_branch (is_branch),
    .is_halt   (is_halt),
    .is_illegal(is_illegal)
  );
  assign operand = ir[OPERAND_W-1:0];
  assign in_exec = state == S_EXEC;
  assign done = !is_mem || mem_ready;
  assign stop = is_halt || is_illegal;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = (run || step) ? S_FETCH : S_IDLE;
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: state_nx = stop ? S_HALT : !done ? S_EXEC : run ? S_FETCH : S_IDLE;
      default: state_nx = state;
    endcase
    sel_a = in_exec ? ctrl.sel_a : SELA_RAM;
    sel_b = in_exec && ctrl.sel_b;
    op = in_exec && ctrl.op;
    wr_acc = in_exec && ctrl.wr_acc && done;
    rd_ram = in_exec && ctrl.rd_ram;
    wr_ram = in_exec && ctrl.wr_ram;
    halted = state == S_HALT;
    busy = state == S_FETCH || state == S_DECODE || in_exec;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc <= '0;
      ir <= '0;
      cycle_cnt <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) ir <= instr;
      if (in_exec && done && !stop) pc <= is_branch ? PC_W'(operand) : pc + 1'b1;
      if (in_exec && is_illegal) illegal <= 1'b1;
      if (busy && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bip_control_fsm.sv
// tb_bip_control_fsm: instruction-level reference model check of the BIP control sequencer
module tb_bip_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1, acc_zero = 1'b0, mem_ready = 1'b1, run = 1'b0, step = 1'b0;
  logic [15:0] instr;
  logic [10:0] pc, operand;
  logic wr_acc, sel_b, op, wr_ram, rd_ram, halted, illegal, busy;
  logic [1:0] sel_a;
  logic [31:0] cycle_cnt;
  logic [6:0] cv;
  logic [15:0] rom [2048];
  int vectors = 0, fails = 0;
  logic [10:0] mpc;
  int mcnt;
  logic mhalt, mill;

  always #5 clk = ~clk;
  always @(posedge clk) instr <= rom[pc];
  assign cv = {sel_a, sel_b, op, wr_acc, rd_ram, wr_ram};

  bip_control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .acc_zero(acc_zero), .mem_ready(mem_ready),
    .run(run), .step(step), .pc(pc), .operand(operand), .wr_acc(wr_acc), .sel_a(sel_a),
    .sel_b(sel_b), .op(op), .wr_ram(wr_ram), .rd_ram(rd_ram), .halted(halted),
    .illegal(illegal), .busy(busy), .cycle_cnt(cycle_cnt)
  );

  function automatic logic [6:0] tab(input logic [4:0] opc);
    case (opc)
      5'd1: return 7'b00_00001;
      5'd2: return 7'b00_00110;
      5'd3: return 7'b01_10100;
      5'd4: return 7'b10_01110;
      5'd5: return 7'b10_11100;
      5'd6: return 7'b10_00110;
      5'd7: return 7'b10_10100;
      default: return 7'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    tick();
    reset = 1'b0;
    mpc = '0;
    mcnt = 0;
    mhalt = 1'b0;
    mill = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ctrl"}, 32'(cv), 0);
    chk({tag, "_pc"}, 32'(pc), 32'(mpc));
    chk({tag, "_cnt"}, cycle_cnt, mcnt);
    chk({tag, "_halted"}, 32'(halted), 32'(mhalt));
    chk({tag, "_illegal"}, 32'(illegal), 32'(mill));
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic idle_cycles(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      run = noisy ? 1'($urandom) : 1'b0;
      step = noisy ? 1'($urandom) : 1'b0;
      mem_ready = 1'($urandom);
      acc_zero = 1'($urandom);
      tick();
      check_quiet(noisy ? "halt_hold" : "idle_hold");
    end
    run = 1'b0;
    step = 1'b0;
  endtask

  task automatic start(input bit use_step);
    if (use_step) begin
      step = 1'b1;
      run = 1'b0;
    end else run = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic exec_one(input logic [4:0] opc, input logic [10:0] opd, input int stalls, input logic az);
    logic [6:0] exp;
    bit mem, stp, taken;
    int last;
    rom[mpc] = {opc, opd};
    mem = opc == 5'd1 || opc == 5'd2 || opc == 5'd4 || opc == 5'd6;
    stp = opc == 5'd0 || opc > 5'd10;
    last = mem ? stalls : 0;
    acc_zero = az;
    mem_ready = 1'($urandom);
    #1;
    chk("fetch_pc", 32'(pc), 32'(mpc));
    chk("fetch_ctrl", 32'(cv), 0);
    chk("fetch_busy", 32'(busy), 1);
    tick();
    mcnt++;
    mem_ready = 1'($urandom);
    #1;
    chk("decode_ctrl", 32'(cv), 0);
    chk("decode_pc", 32'(pc), 32'(mpc));
    tick();
    mcnt++;
    for (int k = 0; k <= last; k++) begin
      mem_ready = mem ? (k == last) : 1'($urandom);
      exp = tab(opc);
      if (k != last) exp[2] = 1'b0;
      #1;
      chk("exec_ctrl", 32'(cv), 32'(exp));
      chk("exec_operand", 32'(operand), 32'(opd));
      chk("exec_pc", 32'(pc), 32'(mpc));
      tick();
      mcnt++;
    end
    taken = (opc == 5'd8 && az) || (opc == 5'd9 && !az) || opc == 5'd10;
    if (stp) begin
      mhalt = 1'b1;
      mill = mill | (opc != 5'd0);
    end else mpc = taken ? opd : mpc + 11'd1;
    chk("done_pc", 32'(pc), 32'(mpc));
    chk("done_halted", 32'(halted), 32'(mhalt));
    chk("done_illegal", 32'(illegal), 32'(mill));
    chk("done_cnt", cycle_cnt, mcnt);
    chk("done_busy", 32'(busy), 32'(!stp && run));
    mem_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 16'(i * 7);
    do_reset();
    check_quiet("reset");
    chk("reset_operand", 32'(operand), 0);
    start(0);
    exec_one(5'd3, 11'd5, 0, 1'b0);
    exec_one(5'd5, 11'd3, 0, 1'b0);
    exec_one(5'd1, 11'd7, 0, 1'b0);
    exec_one(5'd0, 11'd0, 0, 1'b0);
    chk("prog_pc", 32'(pc), 3);
    chk("prog_cnt", cycle_cnt, 12);
    idle_cycles(6, 1'b1);
    do_reset();
    start(0);
    exec_one(5'd2, 11'd4, 3, 1'b0);
    chk("ld_stall_cnt", cycle_cnt, 6);
    run = 1'b0;
    exec_one(5'd8, 11'd9, 0, 1'b1);
    chk("beq_taken_pc", 32'(pc), 9);
    do_reset();
    start(0);
    exec_one(5'd8, 11'd9, 0, 1'b0);
    exec_one(5'd10, 11'd2047, 0, 1'b1);
    chk("jmp_pc", 32'(pc), 2047);
    run = 1'b0;
    exec_one(5'd3, 11'd1, 0, 1'b0);
    chk("wrap_pc", 32'(pc), 0);
    idle_cycles(3, 1'b0);
    start(1);
    exec_one(5'd7, 11'h55, 0, 1'b0);
    chk("step_pc", 32'(pc), 1);
    idle_cycles(3, 1'b0);
    run = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    exec_one(5'd9, 11'd300, 0, 1'b0);
    exec_one(5'd6, 11'd12, 2, 1'b1);
    exec_one(5'd31, 11'h3ff, 0, 1'b0);
    chk("illegal_pc", 32'(pc), 301);
    idle_cycles(6, 1'b1);
    do_reset();
    start(0);
    exec_one(5'd10, 11'd100, 0, 1'b0);
    rom[mpc] = {5'd2, 11'd4};
    mem_ready = 1'b0;
    tick();
    tick();
    chk("stall_rd0", 32'(rd_ram), 1);
    tick();
    chk("stall_rd1", 32'(rd_ram), 1);
    chk("stall_pc", 32'(pc), 100);
    do_reset();
    mem_ready = 1'b1;
    check_quiet("stall_reset");
    start(0);
    for (int i = 0; i < 250; i++) begin
      run = $urandom_range(0, 4) != 0;
      exec_one(5'($urandom_range(1, 10)), 11'($urandom), $urandom_range(0, 3), 1'($urandom));
      if (!run) begin
        idle_cycles($urandom_range(0, 2), 1'b0);
        start(1'($urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
